// File: rtl/icap_pkg.sv
// icap_pkg: shared constants and types for the ICAP streaming controller.
//   - ICAP command words used by the readback header and tail sequences
//   - configuration register addresses
//   - FSM state encoding
//   - sat_inc: 3-bit saturating increment used for sequence word indices
package icap_pkg;

  localparam logic [31:0] ICAP_SYNC    = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOOP    = 32'h2000_0000;
  localparam logic [31:0] ICAP_DESYNC  = 32'h0000_000D;
  localparam logic [31:0] ICAP_CMD_WR1 = 32'h3000_8001;  // type-1 write, CMD reg, 1 word
  localparam logic [31:0] ICAP_T1_RD   = 32'h2800_0001;  // type-1 read, 1 word, addr in [17:13]

  localparam logic [4:0] REG_STAT   = 5'h07;
  localparam logic [4:0] REG_IDCODE = 5'h0C;
  localparam logic [4:0] REG_CMD    = 5'h04;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR        = 3'd1,
    ST_RD_HDR    = 3'd2,
    ST_RD_SWITCH = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_RD_CAP    = 3'd5,
    ST_RD_BACK   = 3'd6,
    ST_RD_TAIL   = 3'd7
  } icap_state_e;

  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
    return (v >= lim) ? lim : v + 3'd1;
  endfunction

endpackage

// File: rtl/icap_rd_seq.sv
// icap_rd_seq: combinational ROM mapping a word index to the command word
// of the readback header (tail=0) or readback tail (tail=1) sequence.
// Ports:
//   tail  in   selects tail sequence instead of header
//   idx   in   word index within the selected sequence
//   addr  in   config register address inserted into the type-1 read
//   word  out  command word for this index
//   last  out  idx is the final word of the selected sequence
//   len   out  number of words in the selected sequence
module icap_rd_seq
  import icap_pkg::*;
#(
  parameter int NOOP_PAD = 2
) (
  input  logic        tail,
  input  logic [2:0]  idx,
  input  logic [4:0]  addr,
  output logic [31:0] word,
  output logic        last,
  output logic [2:0]  len
);

  // Header: SYNC, NOOP, type-1 read, NOOP_PAD x NOOP
  // Tail:   CMD write, DESYNC, NOOP_PAD x NOOP
  localparam logic [2:0] HDR_LEN  = 3'(3 + NOOP_PAD);
  localparam logic [2:0] TAIL_LEN = 3'(2 + NOOP_PAD);

  always_comb begin
    word = ICAP_NOOP;
    if (!tail) begin
      case (idx)
        3'd0:    word = ICAP_SYNC;
        3'd2:    word = ICAP_T1_RD | {14'd0, addr, 13'd0};
        default: word = ICAP_NOOP;
      endcase
    end else begin
      case (idx)
        3'd0:    word = ICAP_CMD_WR1;
        3'd1:    word = ICAP_DESYNC;
        default: word = ICAP_NOOP;
      endcase
    end
  end

  assign len  = tail ? TAIL_LEN : HDR_LEN;
  assign last = (idx == len - 3'd1);

endmodule

// File: rtl/icap_stream_ctrl.sv
// icap_stream_ctrl: ICAP master for the ICAPE3 wrapper (words in natural
// bitstream order). Streams partial bitstream words into ICAP, runs a fixed
// single-register readback sequence, and reports PR status.
// Ports:
//   CLK, RESETN                   clock shared with ICAPE3, async active-low reset
//   s_data/s_valid/s_last/s_ready bitstream word stream
//   rd_req/rd_addr                one-cycle read request and register address
//   rd_data/rd_valid              captured register value and update pulse
//   busy                          high whenever the FSM is not IDLE
//   pr_done/pr_error              registered PRDONE, sticky PRERROR
//   icap_*                        registered ICAP controls and wrapper status
//   dbg_state                     current FSM state (icap_state_e encoding)
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready is only high in WR and follows icap_avail combinationally; the
// source must hold s_data/s_last stable while s_valid is high and unaccepted.
module icap_stream_ctrl
  import icap_pkg::*;
#(
  parameter int RD_LATENCY = 4,
  parameter int NOOP_PAD   = 2
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        rd_req,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        pr_done,
  output logic        pr_error,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic        icap_avail,
  input  logic [31:0] icap_o,
  input  logic        icap_prdone,
  input  logic        icap_prerror,
  output logic [2:0]  dbg_state
);

  icap_state_e state;
  logic [2:0]  idx;
  logic [2:0]  lat;
  logic [4:0]  addr_q;
  logic [31:0] seq_word;
  logic        seq_last;
  logic [2:0]  seq_len;
  logic        wr_fire;

  icap_rd_seq #(.NOOP_PAD(NOOP_PAD)) u_rd_seq (
    .tail (state == ST_RD_TAIL),
    .idx  (idx),
    .addr (addr_q),
    .word (seq_word),
    .last (seq_last),
    .len  (seq_len)
  );

  assign s_ready   = (state == ST_WR) && icap_avail;
  assign wr_fire   = s_valid && s_ready;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // ICAP outputs are registered: what a state decides at an edge is seen on
  // the wrapper pins for the following cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      lat        <= 3'd0;
      addr_q     <= 5'd0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i     <= 32'd0;
      rd_data    <= 32'd0;
      rd_valid   <= 1'b0;
      pr_done    <= 1'b1;
      pr_error   <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      icap_csib <= 1'b1;  // deselected unless this cycle issues a word or read
      pr_done   <= icap_prdone;

      // A new error always wins over the software-initiated clear.
      if (icap_prerror)
        pr_error <= 1'b1;
      else if ((state == ST_IDLE) && (rd_req || s_valid))
        pr_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          icap_rdwrb <= 1'b0;
          if (rd_req) begin
            addr_q <= rd_addr;
            idx    <= 3'd0;
            state  <= ST_RD_HDR;
          end else if (s_valid) begin
            state <= ST_WR;
          end
        end

        ST_WR: begin
          if (wr_fire) begin
            icap_i    <= s_data;
            icap_csib <= 1'b0;
            if (s_last) state <= ST_IDLE;
          end
        end

        ST_RD_HDR, ST_RD_TAIL: begin
          if (icap_avail) begin
            icap_i    <= seq_word;
            icap_csib <= 1'b0;
            if (seq_last) begin
              idx   <= 3'd0;
              state <= (state == ST_RD_HDR) ? ST_RD_SWITCH : ST_IDLE;
            end else begin
              idx <= sat_inc(idx, seq_len);
            end
          end
        end

        // Direction only changes on cycles where CSIB is high.
        ST_RD_SWITCH: begin
          icap_rdwrb <= 1'b1;
          lat        <= 3'(RD_LATENCY - 1);
          state      <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          icap_csib <= 1'b0;
          if (lat == 3'd0) state <= ST_RD_CAP;
          else             lat   <= lat - 3'd1;
        end

        ST_RD_CAP: begin
          rd_data  <= icap_o;
          rd_valid <= 1'b1;
          state    <= ST_RD_BACK;
        end

        ST_RD_BACK: begin
          icap_rdwrb <= 1'b0;
          idx        <= 3'd0;
          state      <= ST_RD_TAIL;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_stream_ctrl.sv
// Testbench for icap_stream_ctrl: table-driven stream and readback vectors
// plus hand-written sequences for arbitration, sticky error and mid-read reset.
module tb_icap_stream_ctrl;
  import icap_pkg::*;

  localparam int RD_LATENCY = 4;
  localparam int NOOP_PAD   = 2;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        pr_done;
  logic        pr_error;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_i;
  logic        icap_avail = 1'b1;
  logic [31:0] icap_o = 32'hDEAD_BEEF;
  logic        icap_prdone = 1'b1;
  logic        icap_prerror = 1'b0;
  logic [2:0]  dbg_state;

  always #5 CLK = ~CLK;

  icap_stream_ctrl #(.RD_LATENCY(RD_LATENCY), .NOOP_PAD(NOOP_PAD)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .pr_done(pr_done), .pr_error(pr_error),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
    .icap_avail(icap_avail), .icap_o(icap_o),
    .icap_prdone(icap_prdone), .icap_prerror(icap_prerror),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];     // expected ICAP write words, in order
  logic [31:0] rd_exp_q[$];  // expected rd_data values
  logic [31:0] model_val = 32'd0;
  int          rd_cnt = 0;
  logic        prev_rdwrb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ICAP read model: data is only valid on O once RD_LATENCY read-enabled
  // cycles have elapsed; any other time O carries junk.
  always @(negedge CLK) begin
    if (!icap_csib && icap_rdwrb) rd_cnt++;
    else rd_cnt = 0;
    icap_o = (rd_cnt == RD_LATENCY) ? model_val : 32'hDEAD_BEEF;

    if (!icap_csib && !icap_rdwrb) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL icap_write: unexpected word %h at %0t", icap_i, $time);
      end else begin
        check("icap_write", icap_i, exp_q.pop_front());
      end
    end
    if (rd_valid) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_valid: unexpected pulse data %h at %0t", rd_data, $time);
      end else begin
        check("rd_data", rd_data, rd_exp_q.pop_front());
      end
    end
    if (icap_rdwrb !== prev_rdwrb) check("dir_change_csib_high", icap_csib, 1);
    prev_rdwrb = icap_rdwrb;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last, input int stall,
                           input logic [31:0] exp);
    int n;
    n = 0;
    s_data = data; s_last = last; s_valid = 1'b1;
    if (stall > 0) begin
      icap_avail = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge CLK);
        check("stall_s_ready", s_ready, 0);
        if (k > 0) check("stall_csib", icap_csib, 1);
      end
      tick();
      icap_avail = 1'b1;
    end
    @(negedge CLK);
    while (!s_ready && n < 50) begin @(negedge CLK); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_word_timeout: s_ready 0 expected 1 for word %h", data);
    end else begin
      exp_q.push_back(exp);
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    check("word_next_cycle_i", icap_i, exp);
    check("word_next_cycle_csib", icap_csib, 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 300) begin @(negedge CLK); n++; end
    check(name, busy, 0);
  endtask

  task automatic push_hdr(input logic [31:0] cmd);
    exp_q.push_back(32'hAA99_5566);
    exp_q.push_back(32'h2000_0000);
    exp_q.push_back(cmd);
    for (int k = 0; k < NOOP_PAD; k++) exp_q.push_back(32'h2000_0000);
  endtask

  task automatic push_tail();
    exp_q.push_back(32'h3000_8001);
    exp_q.push_back(32'h0000_000D);
    for (int k = 0; k < NOOP_PAD; k++) exp_q.push_back(32'h2000_0000);
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] val,
                         input logic [31:0] exp_cmd, input logic [31:0] exp_rd);
    model_val = val;
    rd_addr = addr; rd_req = 1'b1;
    push_hdr(exp_cmd);
    push_tail();
    rd_exp_q.push_back(exp_rd);
    tick();
    rd_req = 1'b0;
    wait_idle("read_busy_falls");
    tick();
    check("read_words_drained", exp_q.size(), 0);
    check("read_rd_drained", rd_exp_q.size(), 0);
    check("rd_data_hold", rd_data, exp_rd);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [31:0] data;
    logic        last;
    int          stall;
    logic [31:0] exp_i;
  } wr_vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] reg_val;
    logic [31:0] exp_cmd;
    logic [31:0] exp_rd;
  } rd_vec_t;

  wr_vec_t wr_vecs[12];
  rd_vec_t rd_vecs[3];

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    logic [31:0] r;

    wr_vecs[0] = '{32'hAA99_5566, 1'b0, 0, 32'hAA99_5566};
    wr_vecs[1] = '{32'h2000_0000, 1'b0, 0, 32'h2000_0000};
    wr_vecs[2] = '{32'h3000_C001, 1'b1, 0, 32'h3000_C001};
    wr_vecs[3] = '{32'h1111_1111, 1'b0, 0, 32'h1111_1111};
    wr_vecs[4] = '{32'h2222_2222, 1'b0, 0, 32'h2222_2222};
    wr_vecs[5] = '{32'h3333_3333, 1'b0, 5, 32'h3333_3333};
    wr_vecs[6] = '{32'h4444_4444, 1'b0, 0, 32'h4444_4444};
    wr_vecs[7] = '{32'h5555_5555, 1'b1, 0, 32'h5555_5555};
    for (int i = 8; i < 12; i++) begin
      r = $urandom;
      wr_vecs[i] = '{r, (i == 11), (i == 8) ? 0 : int'($urandom_range(0, 2)), r};
    end

    r = $urandom;
    rd_vecs[0] = '{5'h07, 32'h1234_5678, 32'h2800_E001, 32'h1234_5678};
    rd_vecs[1] = '{5'h0C, 32'hA5A5_F00F, 32'h2801_8001, 32'hA5A5_F00F};
    rd_vecs[2] = '{5'h1F, r,             32'h2803_E001, r};

    // Reset values
    #12;
    check("rst_csib", icap_csib, 1);
    check("rst_rdwrb", icap_rdwrb, 0);
    check("rst_icap_i", icap_i, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pr_done", pr_done, 1);
    check("rst_pr_error", pr_error, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    tick();

    // Streams, including a 5-cycle AVAIL stall mid-stream
    for (int i = 0; i < 12; i++) begin
      send_word(wr_vecs[i].data, wr_vecs[i].last, wr_vecs[i].stall, wr_vecs[i].exp_i);
      if (wr_vecs[i].last) begin
        @(negedge CLK);
        check("stream_end_busy", busy, 0);
        @(negedge CLK);
        check("stream_end_csib", icap_csib, 1);
        check("stream_drained", exp_q.size(), 0);
      end
    end

    // Readback of several registers
    for (int i = 0; i < 3; i++)
      do_read(rd_vecs[i].addr, rd_vecs[i].reg_val, rd_vecs[i].exp_cmd, rd_vecs[i].exp_rd);

    // rd_req and s_valid together in IDLE: read first, then the stream
    model_val = 32'h0BAD_F00D;
    rd_addr = 5'h0C; rd_req = 1'b1;
    s_data = 32'h5A5A_0004; s_valid = 1'b1; s_last = 1'b1;
    push_hdr(32'h2801_8001);
    push_tail();
    exp_q.push_back(32'h5A5A_0004);
    rd_exp_q.push_back(32'h0BAD_F00D);
    tick();
    rd_req = 1'b0;
    bad = 0; n = 0;
    @(negedge CLK);
    while (dbg_state != ST_WR && n < 200) begin
      if (s_ready) bad++;
      @(negedge CLK); n++;
    end
    check("s_ready_low_during_read", bad, 0);
    check("stream_after_read", dbg_state, ST_WR);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle("arb_busy_falls");
    tick();
    check("arb_drained", exp_q.size(), 0);

    // PRERROR pulse mid-stream (plus an rd_req that must be dropped)
    send_word(32'h0000_0101, 1'b0, 0, 32'h0000_0101);
    icap_prerror = 1'b1; rd_req = 1'b1; rd_addr = 5'h07;
    tick();
    icap_prerror = 1'b0; rd_req = 1'b0;
    send_word(32'h0000_0102, 1'b0, 0, 32'h0000_0102);
    send_word(32'h0000_0103, 1'b1, 0, 32'h0000_0103);
    tick(); tick();
    check("pr_error_sticky", pr_error, 1);
    check("busy_rd_req_dropped", busy, 0);
    check("err_drained", exp_q.size(), 0);
    do_read(rd_vecs[1].addr, rd_vecs[1].reg_val, rd_vecs[1].exp_cmd, rd_vecs[1].exp_rd);
    check("pr_error_cleared_by_rd_req", pr_error, 0);

    // PRDONE is registered
    icap_prdone = 1'b0;
    #1;
    check("pr_done_not_yet", pr_done, 1);
    tick();
    check("pr_done_low", pr_done, 0);
    icap_prdone = 1'b1;
    tick();
    check("pr_done_high", pr_done, 1);

    // Reset during RD_WAIT abandons the read
    model_val = 32'hCAFE_0001;
    rd_addr = 5'h0C; rd_req = 1'b1;
    push_hdr(32'h2801_8001);
    tick();
    rd_req = 1'b0;
    n = 0;
    while (dbg_state != ST_RD_WAIT && n < 100) begin tick(); n++; end
    check("reached_rd_wait", dbg_state, ST_RD_WAIT);
    tick();
    RESETN = 1'b0;
    #1;
    check("midrst_csib", icap_csib, 1);
    check("midrst_rdwrb", icap_rdwrb, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_hdr_drained", exp_q.size(), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    tick();
    do_read(rd_vecs[0].addr, rd_vecs[0].reg_val, rd_vecs[0].exp_cmd, rd_vecs[0].exp_rd);

    tick();
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
